// File: rtl/aemb2_dwb_pkg.sv
// Shared definitions for the AEMB2 data-bus SRAM responder: FSM state
// encoding, wait-state bound and the byte-select patterns the core can issue.
package aemb2_dwb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } dwbState_e;

  localparam int WAIT_MAX = 7;
  localparam int CNT_W    = $clog2(WAIT_MAX + 1);

  localparam logic [3:0] SEL_B3   = 4'h8;
  localparam logic [3:0] SEL_B2   = 4'h4;
  localparam logic [3:0] SEL_B1   = 4'h2;
  localparam logic [3:0] SEL_B0   = 4'h1;
  localparam logic [3:0] SEL_HI   = 4'hC;
  localparam logic [3:0] SEL_LO   = 4'h3;
  localparam logic [3:0] SEL_WORD = 4'hF;

  // Byte, aligned half-word and full-word patterns are the only ones a
  // well-behaved store path produces.
  function automatic logic selLegal(input logic [3:0] sel);
    case (sel)
      SEL_B3, SEL_B2, SEL_B1, SEL_B0, SEL_HI, SEL_LO, SEL_WORD: selLegal = 1'b1;
      default: selLegal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/aemb2_dwb_bram.sv
// 2^AW x 32 single-port array with per-byte write enables and a registered,
// resettable read port.
module aemb2_dwb_bram
  import aemb2_dwb_pkg::*;
#(
  parameter int AW = 10
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [AW-1:0] adr,
  input  logic [3:0]    we,
  input  logic [31:0]   wdat,
  input  logic          re,
  output logic [31:0]   rdat
);

  logic [31:0] mem [2**AW];

  // Array contents are deliberately not reset.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) mem[adr][i*8 +: 8] <= wdat[i*8 +: 8];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdat <= 32'h0;
    end else if (re) begin
      rdat <= mem[adr];
    end
  end

endmodule

// File: rtl/aemb2_dwb_sram.sv
// AEMB2 DWB Wishbone-classic SRAM responder with programmable wait states.
// Define AEMB2_DWB_ERR_EN to answer illegal byte selects with dwb_err_o.
module aemb2_dwb_sram
  import aemb2_dwb_pkg::*;
#(
  parameter int AW   = 10,
  parameter int WAIT = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        dwb_stb_i,
  input  logic        dwb_wre_i,
  input  logic [31:0] dwb_adr_i,
  input  logic [3:0]  dwb_sel_i,
  input  logic [31:0] dwb_dat_i,
  output logic [31:0] dwb_dat_o,
  output logic        dwb_ack_o,
  output logic        dwb_err_o
);

  dwbState_e        state;
  dwbState_e        stateNxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cntNxt;
  logic             goAck;
  logic             selOk;
  logic             commit;
  logic             ackQ;
  logic [3:0]       bramWe;
  logic             bramRe;

  // Address bits outside the word index alias onto the same word.
  logic unusedAdr;
  assign unusedAdr = ^{dwb_adr_i[31:AW+2], dwb_adr_i[1:0]};

`ifdef AEMB2_DWB_ERR_EN
  assign selOk = selLegal(dwb_sel_i);
`else
  assign selOk = 1'b1;
`endif

  always_comb begin
    stateNxt = state;
    cntNxt   = cnt;
    goAck    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (dwb_stb_i) begin
          cntNxt = CNT_W'(WAIT);
          if (WAIT == 0) begin
            stateNxt = ST_ACK;
            goAck    = 1'b1;
          end else begin
            stateNxt = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        cntNxt = cnt - 1'b1;
        if (!dwb_stb_i) begin
          stateNxt = ST_IDLE;
        end else if (cnt == CNT_W'(1)) begin
          stateNxt = ST_ACK;
          goAck    = 1'b1;
        end
      end
      ST_ACK:  stateNxt = ST_IDLE;
      default: stateNxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= ST_IDLE;
      cnt   <= '0;
      ackQ  <= 1'b0;
    end else begin
      state <= stateNxt;
      cnt   <= cntNxt;
      ackQ  <= goAck & selOk;
    end
  end

  // The array has no reset, so a clock edge seen while reset is held must
  // not be allowed to commit the request the FSM would otherwise accept.
  assign commit = goAck & selOk & ~rst_i;
  assign bramWe = {4{commit & dwb_wre_i}} & dwb_sel_i;
  assign bramRe = commit & ~dwb_wre_i;

  aemb2_dwb_bram #(.AW(AW)) u_bram (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .adr   (dwb_adr_i[AW+1:2]),
    .we    (bramWe),
    .wdat  (dwb_dat_i),
    .re    (bramRe),
    .rdat  (dwb_dat_o)
  );

  assign dwb_ack_o = ackQ;

`ifdef AEMB2_DWB_ERR_EN
  logic errQ;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      errQ <= 1'b0;
    end else begin
      errQ <= goAck & ~selOk;
    end
  end
  assign dwb_err_o = errQ;
`else
  assign dwb_err_o = 1'b0;
`endif

endmodule

// File: doc/aemb2_dwb_sram.md
# aemb2_dwb_sram

Single-port on-chip data memory that answers the AEMB2 core's data bus (DWB) as a Wishbone-classic responder. It accepts word-addressed reads and byte-lane-masked writes from the core's store path (lane-replicated store data plus a 4-bit select), inserts a programmable number of wait states, and returns registered read data with a one-cycle acknowledge pulse. It sits on the DWB between the core and the rest of the data address space.

## Interface
- AW, 10, word-address width; memory depth is 2^AW 32-bit words.
- WAIT, 1, wait states inserted before ack (legal 0..7).
- clk_i  in  1  system clock, all state on rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- dwb_stb_i  in  1  request strobe, held until ack (or error) is seen.
- dwb_wre_i  in  1  1 = write, 0 = read; stable while stb high.
- dwb_adr_i  in  32  byte address; bits [AW+1:2] select the word, the rest are ignored (aliasing).
- dwb_sel_i  in  4  byte-lane select, bit 3 = bits [31:24].
- dwb_dat_i  in  32  store data, already lane-replicated by the core.
- dwb_dat_o  out  32  read data, registered.
- dwb_ack_o  out  1  single-cycle completion pulse.
- dwb_err_o  out  1  single-cycle error pulse (only with AEMB2_DWB_ERR_EN; otherwise tied 0).

## Operation
- FSM states: IDLE, WAIT, ACK (encoding in the package).
- IDLE: stb sampled high -> load wait counter with WAIT; go WAIT if WAIT>0, otherwise ACK.
- WAIT: counter decrements each cycle; on the edge where it equals 1 -> ACK. stb low in WAIT -> abort to IDLE with no write and no ack.
- Entering ACK (same edge): write commits lanes with sel bit set, others keep old value; read loads the full word into dwb_dat_o. Core does byte/half extraction itself.
- ACK: dwb_ack_o = 1 for exactly that cycle; next state is always IDLE. The core drops or changes stb on the edge that samples ack.
- dwb_dat_o holds its value until the next completed read; writes never change it.
- Legal sel: 8,4,2,1,C,3,F. Illegal sel (0,5,6,7,9,A,B,D,E): see Configuration.
- Memory contents are not reset; simulation initialises them to random values.

## Timing
- Reset: state IDLE, counter 0, dwb_ack_o 0, dwb_err_o 0, dwb_dat_o 32'h0. Asserted mid-transaction: transaction lost, no write committed, no ack.
- Latency stb-sampled to ack high: WAIT+1 cycles.
- Minimum transaction period: WAIT+2 cycles (one mandatory IDLE after every ACK).
- stb high in the ACK cycle is not a new request; only IDLE samples stb.
- Write-then-read to the same word returns the newly written data (write commits before the read's IDLE cycle).

## Configuration
- AEMB2_DWB_ERR_EN defined: illegal sel completes through the normal wait sequence but pulses dwb_err_o instead of dwb_ack_o; no write occurs, dwb_dat_o unchanged.
- Undefined: dwb_err_o tied 0; illegal sel writes exactly the selected lanes (reads unaffected) and acks normally.

## Structure
- Package aemb2_dwb_pkg: FSM state typedef/encodings, legal-sel constants, WAIT upper bound.
- Sub-module aemb2_dwb_bram: 2^AW x 32 array with four byte write-enables and registered read port; the top holds the FSM, counter, and ack/err generation.

## Test plan
- WAIT=1: write adr 0x10, sel F, data 0xDEADBEEF; read 0x10 -> ack 2 cycles after stb sampled, dwb_dat_o = 0xDEADBEEF.
- Byte write adr 0x10, sel 4, data 0x55555555 over 0xDEADBEEF; read -> 0xDE55BEEF; half write sel 3 data 0x12341234 -> 0xDE551234.
- WAIT=0 back-to-back reads of 0x0 and 0x4 -> ack pulses 2 cycles apart, each exactly 1 cycle wide.
- stb dropped during WAIT (WAIT=3) on a write -> no ack, word unchanged on readback.
- rst_i asserted asynchronously mid-WAIT -> ack/err/dat_o go 0 immediately, no write; next transaction normal.
- With AEMB2_DWB_ERR_EN, write sel 5 -> dwb_err_o pulse, no ack, memory unchanged; without macro -> ack, lanes 2 and 0 written.
